// File: rtl/ccff_prog_pkg.sv
// Shared state encoding and default sizing for the configuration-chain programmer.
package ccff_prog_pkg;

  localparam int CCFF_BITSTREAM_SIZE = 29696;
  localparam int CCFF_WORD_W         = 32;
  localparam int CCFF_CHECK_MARGIN   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROG  = 2'd1,
    CHECK = 2'd2
  } ccff_state_e;

endpackage

// File: rtl/ccff_bit_serializer.sv
// One-word bitstream buffer: MSB-first shifting, same-cycle refill, and truncation of the final partial word.
module ccff_bit_serializer #(
  parameter int WORD_W = 32,
  parameter int CW     = 15
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              flush,
  input  logic              run,
  input  logic              load,
  input  logic [WORD_W-1:0] word_data,
  input  logic [CW-1:0]     bits_left,
  output logic              bit_avail,
  output logic              bit_out,
  output logic              empty_next
);

  localparam int NW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sreg;
  logic [NW-1:0]     cnt;
  logic [NW-1:0]     cnt_nxt;
  logic [NW-1:0]     load_bits;
  logic              have_bits;

  always_comb begin
    have_bits = (cnt != '0);
    load_bits = (bits_left < CW'(WORD_W)) ? NW'(bits_left) : NW'(WORD_W);
    bit_avail = run && (have_bits || load);
    // An empty buffer forwards the incoming MSB directly so refill costs no cycle.
    bit_out   = have_bits ? sreg[WORD_W-1] : word_data[WORD_W-1];
    cnt_nxt   = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (run) begin
      if (have_bits) begin
        cnt_nxt = cnt - NW'(1);
      end else if (load) begin
        cnt_nxt = load_bits - NW'(1);
      end
    end
    empty_next = (cnt_nxt == '0);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      cnt  <= '0;
      sreg <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (!flush && run) begin
        if (have_bits) begin
          sreg <= sreg << 1;
        end else if (load) begin
          sreg <= word_data << 1;
        end
      end
    end
  end

endmodule

// File: rtl/ccff_prog_ctrl.sv
// Configuration-chain programmer: streams words into the CCFF chain and optionally runs a chain check.
// Chain check logic is built only when CCFF_CHAIN_CHECK_EN is defined.
module ccff_prog_ctrl
  import ccff_prog_pkg::*;
#(
  parameter int BITSTREAM_SIZE = CCFF_BITSTREAM_SIZE,
  parameter int WORD_W         = CCFF_WORD_W,
  parameter int CHECK_MARGIN   = CCFF_CHECK_MARGIN
) (
  input  logic                                             prog_clk,
  input  logic                                             pReset,
  input  logic                                             start,
  input  logic                                             check_mode,
  input  logic                                             abort,
  input  logic [WORD_W-1:0]                                word_data,
  input  logic                                             word_valid,
  output logic                                             word_ready,
  output logic                                             ccff_head,
  input  logic                                             ccff_tail,
  output logic                                             clk_en,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             error,
  output logic [$clog2(BITSTREAM_SIZE+CHECK_MARGIN+1)-1:0] bit_count
);

  localparam int CW = $clog2(BITSTREAM_SIZE + CHECK_MARGIN + 1);

  ccff_state_e state;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] bits_left;
  logic          run;
  logic          load;
  logic          bit_avail;
  logic          bit_out;
  logic          empty_next;

  // count_inc includes the bit on ccff_head this cycle, i.e. bits already issued.
  always_comb begin
    count_inc = bit_count + CW'(clk_en);
    bits_left = CW'(BITSTREAM_SIZE) - count_inc;
    run       = (state == PROG) && !abort;
    load      = run && word_valid && word_ready;
  end

  ccff_bit_serializer #(
    .WORD_W (WORD_W),
    .CW     (CW)
  ) u_serializer (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .flush      (abort),
    .run        (run),
    .load       (load),
    .word_data  (word_data),
    .bits_left  (bits_left),
    .bit_avail  (bit_avail),
    .bit_out    (bit_out),
    .empty_next (empty_next)
  );

`ifndef CCFF_CHAIN_CHECK_EN
  logic unused_check_inputs;
  assign unused_check_inputs = ^{check_mode, ccff_tail};
  assign error = 1'b0;
`endif

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state      <= IDLE;
      ccff_head  <= 1'b0;
      clk_en     <= 1'b0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_count  <= '0;
`ifdef CCFF_CHAIN_CHECK_EN
      error      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        clk_en     <= 1'b0;
        word_ready <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              bit_count <= '0;
              busy      <= 1'b1;
`ifdef CCFF_CHAIN_CHECK_EN
              error     <= 1'b0;
              if (check_mode) begin
                state     <= CHECK;
                clk_en    <= 1'b1;
                ccff_head <= 1'b1;
              end else begin
                state      <= PROG;
                word_ready <= 1'b1;
              end
`else
              state      <= PROG;
              word_ready <= 1'b1;
`endif
            end
          end
          PROG: begin
            bit_count <= count_inc;
            if (count_inc == CW'(BITSTREAM_SIZE)) begin
              done       <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
              clk_en     <= 1'b0;
              ccff_head  <= 1'b0;
              word_ready <= 1'b0;
            end else begin
              clk_en     <= bit_avail;
              if (bit_avail) begin
                ccff_head <= bit_out;
              end
              word_ready <= empty_next && ((count_inc + CW'(bit_avail)) < CW'(BITSTREAM_SIZE));
            end
          end
`ifdef CCFF_CHAIN_CHECK_EN
          CHECK: begin
            // bit_count is frozen on the verdict edge so it reports where the tail was judged.
            if (ccff_tail || (bit_count == CW'(BITSTREAM_SIZE + CHECK_MARGIN))) begin
              done      <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              clk_en    <= 1'b0;
              ccff_head <= 1'b0;
              error     <= !(ccff_tail && (bit_count == CW'(BITSTREAM_SIZE)));
            end else begin
              bit_count <= bit_count + CW'(1);
              ccff_head <= 1'b0;
            end
          end
`endif
          default: begin
            state      <= IDLE;
            clk_en     <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// Directed bench for ccff_prog_ctrl with a 20-FF (and 19-FF) chain model, 8-bit words.
module tb_ccff_prog_ctrl;

  localparam int SIZE   = 20;
  localparam int WW     = 8;
  localparam int MARGIN = 16;
  localparam int CW     = $clog2(SIZE + MARGIN + 1);

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          check_mode;
  logic          abort;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          ccff_head;
  logic          ccff_tail;
  logic          clk_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] bit_count;

  int n_chk = 0;
  int n_bad = 0;

  logic [19:0]   chain20 = '0;
  logic [18:0]   chain19 = '0;
  int            hs_cnt = 0;
  int            en_total = 0;
  int            idle_busy = 0;
  int            run_len = 0;
  int            hs_base = 0;
  int            en0 = 0;
  int            ib0 = 0;
  int            tail_sel = 0;
  logic [WW-1:0] words [4];
  logic [1:0]    widx;

  always #5 prog_clk = ~prog_clk;

  assign widx      = 2'(hs_cnt - hs_base);
  assign word_data = words[widx];
  assign ccff_tail = (tail_sel == 0) ? chain20[19] : (tail_sel == 1) ? chain19[18] : 1'b0;

  ccff_prog_ctrl #(
    .BITSTREAM_SIZE (SIZE),
    .WORD_W         (WW),
    .CHECK_MARGIN   (MARGIN)
  ) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .start      (start),
    .check_mode (check_mode),
    .abort      (abort),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .clk_en     (clk_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bit_count  (bit_count)
  );

  // Chain and handshake model; reads pre-edge values of the DUT outputs.
  always @(posedge prog_clk) begin
    if (clk_en) begin
      chain20  <= {chain20[18:0], ccff_head};
      chain19  <= {chain19[17:0], ccff_head};
      en_total <= en_total + 1;
      run_len  <= run_len + 1;
    end else begin
      run_len  <= 0;
    end
    if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
    if (busy && !clk_en) idle_busy <= idle_busy + 1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic set_words(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    words[0] = a;
    words[1] = b;
    words[2] = c;
    words[3] = 8'hFF;
  endtask

  task automatic do_start(input logic cm);
    @(negedge prog_clk);
    hs_base    = hs_cnt;
    en0        = en_total;
    ib0        = idle_busy;
    start      = 1'b1;
    check_mode = cm;
    @(negedge prog_clk);
    start      = 1'b0;
    check_mode = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    if (!ok) chk_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_full(input logic cm, input logic [19:0] exp_chain);
    bit ok;
    word_valid = 1'b1;
    do_start(cm);
    chk_eq("p0_ready", 32'(word_ready), 32'd1);
    chk_eq("p0_busy", 32'(busy), 32'd1);
    wait_done(60, ok);
    if (ok) begin
      chk_eq("prog_bitcnt", 32'(bit_count), 32'd20);
      chk_eq("prog_chain", 32'(chain20), 32'(exp_chain));
      chk_eq("prog_handshakes", 32'(hs_cnt - hs_base), 32'd3);
      chk_eq("prog_shifts", 32'(en_total - en0), 32'd20);
      chk_eq("prog_run", 32'(run_len), 32'd20);
      chk_eq("prog_gaps", 32'(idle_busy - ib0), 32'd1);
      chk_eq("done_clk_en", 32'(clk_en), 32'd0);
      chk_eq("done_head", 32'(ccff_head), 32'd0);
      chk_eq("done_busy", 32'(busy), 32'd0);
      chk_eq("prog_error", 32'(error), 32'd0);
    end
    @(negedge prog_clk);
    chk_eq("done_pulse", 32'(done), 32'd0);
  endtask

`ifdef CCFF_CHAIN_CHECK_EN
  task automatic run_check(input int sel, input int exp_bc, input logic exp_err);
    bit ok;
    set_words(8'h00, 8'h00, 8'h00);
    tail_sel = 0;
    run_full(1'b0, 20'h00000);
    tail_sel = sel;
    do_start(1'b1);
    chk_eq("chk_p0_en", 32'(clk_en), 32'd1);
    chk_eq("chk_p0_head", 32'(ccff_head), 32'd1);
    chk_eq("chk_p0_err", 32'(error), 32'd0);
    wait_done(60, ok);
    if (ok) begin
      chk_eq("chk_bitcnt", 32'(bit_count), 32'(exp_bc));
      chk_eq("chk_error", 32'(error), 32'(exp_err));
      chk_eq("chk_clk_en", 32'(clk_en), 32'd0);
      chk_eq("chk_no_hs", 32'(hs_cnt - hs_base), 32'd0);
    end
    tail_sel = 0;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stalled;
    bit ok;
    pReset = 1'b0; start = 1'b0; check_mode = 1'b0; abort = 1'b0; word_valid = 1'b0;
    set_words(8'hA5, 8'h3C, 8'hF0);
    repeat (3) @(negedge prog_clk);
    chk_eq("rst_clk_en", 32'(clk_en), 32'd0);
    chk_eq("rst_ready", 32'(word_ready), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_error", 32'(error), 32'd0);
    chk_eq("rst_bitcnt", 32'(bit_count), 32'd0);
    chk_eq("rst_head", 32'(ccff_head), 32'd0);
    pReset = 1'b1;

    // Baseline: A5, 3C, F0 streamed with no gaps.
    run_full(1'b0, 20'hA53CF);

    // Five ready cycles with word_valid low; a start while busy must be ignored.
    set_words(8'hA5, 8'h3C, 8'hF0);
    word_valid = 1'b1;
    do_start(1'b0);
    for (int i = 0; i < 10 && (hs_cnt - hs_base) < 1; i++) @(negedge prog_clk);
    word_valid = 1'b0;
    stalled = 0;
    for (int i = 0; i < 40 && stalled < 5; i++) begin
      @(negedge prog_clk);
      start      = (i == 1);
      check_mode = (i == 1);
      if (word_ready) stalled++;
    end
    start = 1'b0; check_mode = 1'b0;
    chk_eq("stall_cnt", 32'(stalled), 32'd5);
    @(negedge prog_clk);
    word_valid = 1'b1;
    wait_done(60, ok);
    if (ok) begin
      chk_eq("stall_bitcnt", 32'(bit_count), 32'd20);
      chk_eq("stall_chain", 32'(chain20), 32'hA53CF);
      chk_eq("stall_handshakes", 32'(hs_cnt - hs_base), 32'd3);
      chk_eq("stall_shifts", 32'(en_total - en0), 32'd20);
      chk_eq("stall_gaps", 32'(idle_busy - ib0), 32'd6);
      chk_eq("stall_run", 32'(run_len), 32'd12);
    end

    // Abort at bit_count 10, then a clean restart.
    set_words(8'hA5, 8'h3C, 8'hF0);
    do_start(1'b0);
    for (int i = 0; i < 40 && bit_count != CW'(10); i++) @(negedge prog_clk);
    chk_eq("abort_reach", 32'(bit_count), 32'd10);
    chk_eq("abort_pre_en", 32'(clk_en), 32'd1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk_eq("abort_clk_en", 32'(clk_en), 32'd0);
    chk_eq("abort_busy", 32'(busy), 32'd0);
    chk_eq("abort_ready", 32'(word_ready), 32'd0);
    chk_eq("abort_bitcnt", 32'(bit_count), 32'd10);
    for (int i = 0; i < 3; i++) begin
      chk_eq("abort_no_done", 32'(done), 32'd0);
      @(negedge prog_clk);
    end
    run_full(1'b0, 20'hA53CF);

    // Start and abort together in IDLE.
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    chk_eq("sa_busy", 32'(busy), 32'd0);
    chk_eq("sa_clk_en", 32'(clk_en), 32'd0);
    chk_eq("sa_ready", 32'(word_ready), 32'd0);

`ifdef CCFF_CHAIN_CHECK_EN
    run_check(0, 20, 1'b0);
    run_check(1, 19, 1'b1);
    repeat (3) @(negedge prog_clk);
    chk_eq("err_sticky", 32'(error), 32'd1);
    run_check(2, 36, 1'b1);
    set_words(8'hA5, 8'h3C, 8'hF0);
    run_full(1'b0, 20'hA53CF);
`else
    // Without the check feature, check_mode is ignored and start programs.
    set_words(8'h5A, 8'hC3, 8'h0F);
    run_full(1'b1, 20'h5AC30);
`endif

    // Asynchronous reset in the middle of programming.
    set_words(8'hA5, 8'h3C, 8'hF0);
    do_start(1'b0);
    repeat (5) @(negedge prog_clk);
    chk_eq("mid_pre_en", 32'(clk_en), 32'd1);
    pReset = 1'b0;
    #1;
    chk_eq("mid_rst_clk_en", 32'(clk_en), 32'd0);
    chk_eq("mid_rst_busy", 32'(busy), 32'd0);
    chk_eq("mid_rst_ready", 32'(word_ready), 32'd0);
    chk_eq("mid_rst_bitcnt", 32'(bit_count), 32'd0);
    chk_eq("mid_rst_head", 32'(ccff_head), 32'd0);
    chk_eq("mid_rst_done", 32'(done), 32'd0);
    chk_eq("mid_rst_error", 32'(error), 32'd0);
    @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    chk_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
